// File: rtl/imem_loader_if.sv
// Bus bundle between the UART-driven instruction-memory loader and its surroundings.
// master: the loader itself; slave: the UART/CPU/memory side that drives start, rx_* and cpu_addr.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_we;
  logic                  cpu_stall;
  logic                  done;
  logic                  err;

  modport master (
    input  start, rx_valid, rx_data, cpu_addr,
    output mem_addr, mem_data, mem_we, cpu_stall, done, err
  );

  modport slave (
    output start, rx_valid, rx_data, cpu_addr,
    input  mem_addr, mem_data, mem_we, cpu_stall, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a UART byte stream: header word count, then little-endian words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.master bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, LOAD, CHK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, LOAD, DONE} state_t;
`endif

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [ADDR_WIDTH-1:0] hdr_last;
  logic [1:0]            byte_cnt;
  logic [23:0]           asm_reg;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_we_q;
  logic                  byte_acc;
  logic                  word_done;
  logic                  last_word;

  assign byte_acc  = bus.rx_valid && (state == LOAD);
  assign word_done = byte_acc && (byte_cnt == 2'd3);
  // word_idx already points at the word being assembled, so this flags the final word.
  assign last_word = word_done && (word_idx == last_idx);

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_addr = bus.cpu_stall ? word_idx : bus.cpu_addr;

  // Header byte to index of the final word; 0 or an oversize count means a full memory.
  always_comb begin
    hdr_last = ADDR_WIDTH'(DEPTH - 1);
    if (bus.rx_data != 8'd0 && 32'(bus.rx_data) <= DEPTH)
      hdr_last = ADDR_WIDTH'(32'(bus.rx_data) - 32'd1);
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    bus.done      = 1'b0;
    bus.cpu_stall = 1'b1;
    unique case (state)
      IDLE: begin
        bus.cpu_stall = 1'b0;
        if (bus.start) state_next = HDR;
      end
      HDR:  if (bus.rx_valid) state_next = LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      LOAD: if (last_word) state_next = CHK;
      CHK:  if (bus.rx_valid) state_next = DONE;
`else
      LOAD: if (last_word) state_next = DONE;
`endif
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      last_idx   <= '0;
      byte_cnt   <= '0;
      asm_reg    <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      state    <= state_next;
      mem_we_q <= word_done;
      if (state == IDLE && bus.start) begin
        word_idx <= '0;
        byte_cnt <= '0;
        asm_reg  <= '0;
      end
      if (state == HDR && bus.rx_valid) last_idx <= hdr_last;
      if (byte_acc) begin
        byte_cnt <= byte_cnt + 2'd1;
        unique case (byte_cnt)
          2'd0: asm_reg[7:0]   <= bus.rx_data;
          2'd1: asm_reg[15:8]  <= bus.rx_data;
          2'd2: asm_reg[23:16] <= bus.rx_data;
          2'd3: mem_data_q     <= {bus.rx_data, asm_reg};
          default: ;
        endcase
      end
      // Advance after the write cycle; holding at the final index keeps it in range.
      if (mem_we_q && word_idx != last_idx) word_idx <= word_idx + 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        xor_q <= 8'd0;
        err_q <= 1'b0;
      end
      if (byte_acc) xor_q <= xor_q ^ bus.rx_data;
      if (state == CHK && bus.rx_valid && bus.rx_data != xor_q) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, basic load, full-depth back-to-back load, ignored inputs,
// mid-load reset and checksum handling (both builds of IMEM_LOADER_CHECKSUM_EN).
module tb_imem_loader;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_count = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  // Passive write/done recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_data);
    end
    if (bus.done) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cpu_addr = 6'h2A;
    tick();
    tick();
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", bus.mem_we); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_cpu_stall got=%0b exp=0", bus.cpu_stall); end
    checks++; if (bus.mem_data !== 32'h0) begin failures++; $display("FAIL reset_mem_data got=%h exp=00000000", bus.mem_data); end
    checks++; if (bus.mem_addr !== 6'h2A) begin failures++; $display("FAIL reset_mem_addr got=%h exp=2a", bus.mem_addr); end
    rst = 1'b0;
    tick();
    bus.cpu_addr = 6'h15;
    #1;
    checks++; if (bus.mem_addr !== 6'h15) begin failures++; $display("FAIL idle_addr_mux got=%h exp=15", bus.mem_addr); end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8];
    int d0;
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_log();
    d0 = done_count;
    pulse_start();
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL basic_stall_hdr got=%0b exp=1", bus.cpu_stall); end
    send_byte(8'h02);
    tick();
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      if (i == 3) begin
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd0 || bus.mem_data !== 32'h00000013) begin
          failures++; $display("FAIL basic_word0 got we=%0b addr=%0d data=%h exp we=1 addr=0 data=00000013", bus.mem_we, bus.mem_addr, bus.mem_data);
        end
      end
      if (i == 4) begin
        checks++; if (bus.mem_addr !== 6'd1) begin failures++; $display("FAIL basic_load_index got=%0d exp=1", bus.mem_addr); end
      end
      if (i < 7) tick();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    tick();
    send_byte(8'h90);
`else
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd1 || bus.mem_data !== 32'h00100093) begin
      failures++; $display("FAIL basic_word1 got we=%0b addr=%0d data=%h exp we=1 addr=1 data=00100093", bus.mem_we, bus.mem_addr, bus.mem_data);
    end
`endif
    checks++; if (bus.done !== 1'b1 || bus.cpu_stall !== 1'b1) begin
      failures++; $display("FAIL basic_done_cycle got done=%0b stall=%0b exp done=1 stall=1", bus.done, bus.cpu_stall);
    end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL basic_after_done got done=%0b stall=%0b we=%0b exp 0 0 0", bus.done, bus.cpu_stall, bus.mem_we);
    end
    checks++; if (bus.mem_addr !== 6'h15) begin failures++; $display("FAIL basic_addr_back_to_cpu got=%h exp=15", bus.mem_addr); end
    checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL basic_write_count got=%0d exp=2", log_addr.size()); end
    else begin
      checks++; if (log_addr[0] !== 6'd0 || log_data[0] !== 32'h00000013) begin
        failures++; $display("FAIL basic_log0 got addr=%0d data=%h exp addr=0 data=00000013", log_addr[0], log_data[0]);
      end
      checks++; if (log_addr[1] !== 6'd1 || log_data[1] !== 32'h00100093) begin
        failures++; $display("FAIL basic_log1 got addr=%0d data=%h exp addr=1 data=00100093", log_addr[1], log_data[1]);
      end
    end
    checks++; if (done_count - d0 !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_count - d0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [31:0] exp_data;
    logic [7:0]  b;
    clear_log();
    d0 = done_count;
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tick();
    end
    bus.rx_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    tick();
    tick();
    checks++; if (log_addr.size() !== 64) begin failures++; $display("FAIL full_write_count got=%0d exp=64", log_addr.size()); end
    else begin
      for (int w = 0; w < 64; w++) begin
        exp_data = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        checks++; if (log_addr[w] !== 6'(w) || log_data[w] !== exp_data) begin
          failures++; $display("FAIL full_word%0d got addr=%0d data=%h exp addr=%0d data=%h", w, log_addr[w], log_data[w], w, exp_data);
        end
      end
    end
    checks++; if (done_count - d0 !== 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", done_count - d0); end
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL full_stall_end got=%0b exp=0", bus.cpu_stall); end
  endtask

  task automatic test_ignore();
    clear_log();
    send_byte(8'hAA);
    send_byte(8'h55);
    checks++; if (bus.cpu_stall !== 1'b0 || log_addr.size() !== 0) begin
      failures++; $display("FAIL ignore_idle_rx got stall=%0b writes=%0d exp stall=0 writes=0", bus.cpu_stall, log_addr.size());
    end
    bus.start = 1'b1;
    tick();
    send_byte(8'h01);
    send_byte(8'h11);
    tick();
    tick();
    send_byte(8'h22);
    send_byte(8'h33);
    checks++; if (bus.cpu_stall !== 1'b1 || log_addr.size() !== 0) begin
      failures++; $display("FAIL ignore_start_in_load got stall=%0b writes=%0d exp stall=1 writes=0", bus.cpu_stall, log_addr.size());
    end
    bus.start = 1'b0;
    send_byte(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    tick();
    tick();
    checks++; if (log_addr.size() !== 1) begin failures++; $display("FAIL ignore_write_count got=%0d exp=1", log_addr.size()); end
    else begin
      checks++; if (log_addr[0] !== 6'd0 || log_data[0] !== 32'h44332211) begin
        failures++; $display("FAIL ignore_word got addr=%0d data=%h exp addr=0 data=44332211", log_addr[0], log_data[0]);
      end
    end
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL ignore_back_idle got=%0b exp=0", bus.cpu_stall); end
  endtask

  task automatic test_reset_midload();
    clear_log();
    pulse_start();
    send_byte(8'h02);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    rst = 1'b1;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b0 || bus.done !== 1'b0 || bus.mem_data !== 32'h0) begin
      failures++; $display("FAIL midrst_outputs got stall=%0b we=%0b done=%0b data=%h exp 0 0 0 00000000", bus.cpu_stall, bus.mem_we, bus.done, bus.mem_data);
    end
    checks++; if (bus.mem_addr !== 6'h15) begin failures++; $display("FAIL midrst_addr got=%h exp=15", bus.mem_addr); end
    tick();
    rst = 1'b0;
    send_byte(8'hA6);
    send_byte(8'hA7);
    tick();
    checks++; if (log_addr.size() !== 1) begin failures++; $display("FAIL midrst_write_count got=%0d exp=1", log_addr.size()); end
    else begin
      checks++; if (log_addr[0] !== 6'd0 || log_data[0] !== 32'hA3A2A1A0) begin
        failures++; $display("FAIL midrst_word0 got addr=%0d data=%h exp addr=0 data=a3a2a1a0", log_addr[0], log_data[0]);
      end
    end
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    tick();
    tick();
    checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL midrst_reload_count got=%0d exp=2", log_addr.size()); end
    else begin
      checks++; if (log_addr[1] !== 6'd0 || log_data[1] !== 32'hDDCCBBAA) begin
        failures++; $display("FAIL midrst_reload got addr=%0d data=%h exp addr=0 data=ddccbbaa", log_addr[1], log_data[1]);
      end
    end
  endtask

  task automatic test_checksum();
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h0F);
    checks++; if (bus.err !== 1'b0 || bus.done !== 1'b1) begin
      failures++; $display("FAIL chk_good got err=%0b done=%0b exp err=0 done=1", bus.err, bus.done);
    end
    tick();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    send_byte(8'h0E);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL chk_bad got err=%0b exp=1", bus.err); end
    tick();
    tick();
    checks++; if (bus.err !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      failures++; $display("FAIL chk_sticky got err=%0b stall=%0b exp err=1 stall=0", bus.err, bus.cpu_stall);
    end
    pulse_start();
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL chk_clear_on_start got=%0b exp=0", bus.err); end
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    send_byte(8'h0F);
    tick();
`else
    checks++; if (bus.err !== 1'b0 || bus.done !== 1'b1) begin
      failures++; $display("FAIL nochk_done got err=%0b done=%0b exp err=0 done=1", bus.err, bus.done);
    end
    tick();
    send_byte(8'h0E);
    checks++; if (bus.err !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      failures++; $display("FAIL nochk_idle got err=%0b stall=%0b exp err=0 stall=0", bus.err, bus.cpu_stall);
    end
`endif
    checks++; if (log_addr.size() < 1 || log_data[0] !== 32'h08040201) begin
      failures++; $display("FAIL chk_word got writes=%0d exp data=08040201", log_addr.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cpu_addr = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore();
    test_reset_midload();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
